// File: rtl/spi_flash_model_p.sv
// SPI NOR-flash slave model: oversampled SPI mode-0 front end, READ (0x03) and
// FAST READ (0x0B) decode, word streaming with auto-increment and wrap, plus a
// backdoor load port into the word memory.
module spi_flash_model_p #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned ADDR_BYTES   = 3,
    parameter int unsigned DUMMY_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy,
    output logic              cmd_err,
    output logic [15:0]       word_cnt
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned ADDR_BITS = 8 * ADDR_BYTES;
    localparam int unsigned MAX_BITS  = (DATA_W > 32) ? DATA_W : 32;
    localparam int unsigned CNT_W     = $clog2(MAX_BITS) + 1;
    localparam logic [7:0]  OP_READ   = 8'h03;
    localparam logic [7:0]  OP_FAST   = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [2:0] cs_sync;
    logic [2:0] sck_sync;
    logic [1:0] mosi_sync;

    state_t            state_q,    state_n;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_n;
    logic [7:0]        cmd_q,      cmd_n;
    logic [ADDR_W-1:0] addr_q,     addr_n;
    logic [DATA_W-1:0] shift_q,    shift_n;
    logic              miso_q,     miso_n;
    logic              busy_q,     busy_n;
    logic              cmd_err_q,  cmd_err_n;
    logic [15:0]       word_cnt_q, word_cnt_n;

    logic              sck_rise_c, sck_fall_c, cs_fall_c, cs_rise_c, mosi_c;
    logic [7:0]        cmd_shift_c;
    logic [ADDR_W-1:0] addr_shift_c;
    logic [ADDR_W-1:0] addr_inc_c;

    // Pin synchronizers run free through reset so a CS already low at release
    // shows no falling edge afterwards.
    always_ff @(posedge clk) begin
        cs_sync   <= {cs_sync[1:0], spi_cs};
        sck_sync  <= {sck_sync[1:0], spi_sck};
        mosi_sync <= {mosi_sync[0], spi_mosi};
    end

    assign sck_rise_c   =  sck_sync[1] & ~sck_sync[2];
    assign sck_fall_c   = ~sck_sync[1] &  sck_sync[2];
    assign cs_fall_c    = ~cs_sync[1]  &  cs_sync[2];
    assign cs_rise_c    =  cs_sync[1]  & ~cs_sync[2];
    assign mosi_c       =  mosi_sync[1];
    assign cmd_shift_c  = 8'({cmd_q, mosi_c});
    assign addr_shift_c = ADDR_W'({addr_q, mosi_c});
    assign addr_inc_c   = addr_q + ADDR_W'(1);

    // Backdoor load port; memory is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            cmd_q      <= cmd_n;
            addr_q     <= addr_n;
            shift_q    <= shift_n;
            miso_q     <= miso_n;
            busy_q     <= busy_n;
            cmd_err_q  <= cmd_err_n;
            word_cnt_q <= word_cnt_n;
        end
    end

    // Next-state and datapath logic; CS release overrides any SCK activity.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        cmd_n      = cmd_q;
        addr_n     = addr_q;
        shift_n    = shift_q;
        miso_n     = miso_q;
        cmd_err_n  = cmd_err_q;
        word_cnt_n = word_cnt_q;
        busy_n     = ~cs_sync[1];

        if (cs_rise_c) begin
            state_n = ST_IDLE;
            miso_n  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_n = 1'b0;
                    if (cs_fall_c) begin
                        state_n    = ST_CMD;
                        bit_cnt_n  = '0;
                        cmd_err_n  = 1'b0;
                        word_cnt_n = '0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_c) begin
                        cmd_n     = cmd_shift_c;
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_n = '0;
                            if (cmd_shift_c == OP_READ || cmd_shift_c == OP_FAST) begin
                                state_n = ST_ADDR;
                            end else begin
                                state_n   = ST_IGNORE;
                                cmd_err_n = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_c) begin
                        addr_n    = addr_shift_c;
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                            bit_cnt_n = '0;
                            if (cmd_q == OP_FAST && DUMMY_CYCLES != 0) begin
                                state_n = ST_DUMMY;
                            end else begin
                                state_n = ST_DATA;
                                shift_n = mem[addr_shift_c];
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise_c) begin
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            bit_cnt_n = '0;
                            state_n   = ST_DATA;
                            shift_n   = mem[addr_q];
                        end
                    end
                end
                ST_DATA: begin
                    // Each SCK fall presents the next MSB; the last bit of a word
                    // also counts it and fetches the following (wrapping) word.
                    if (sck_fall_c) begin
                        miso_n    = shift_q[DATA_W-1];
                        shift_n   = shift_q << 1;
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_n = '0;
                            addr_n    = addr_inc_c;
                            shift_n   = mem[addr_inc_c];
                            if (word_cnt_q != 16'hFFFF) begin
                                word_cnt_n = word_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                ST_IGNORE: begin
                    miso_n = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                    miso_n  = 1'b0;
                end
            endcase
        end
    end

    assign spi_miso = miso_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_spi_flash_model_p.sv
// Bench for spi_flash_model_p: an SPI master driven from clk-aligned tasks with a
// scoreboard queue of expected words built from a local memory image.
module tb_spi_flash_model_p;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned HALF   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_cs;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;
    logic              cmd_err;
    logic [15:0]       word_cnt;

    logic [DATA_W-1:0] mem_model [16];
    logic [DATA_W-1:0] exp_q [$];
    int                n_checks = 0;
    int                n_pass   = 0;

    spi_flash_model_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_BYTES(3), .DUMMY_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy),
        .cmd_err(cmd_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCK period: MOSI set while low, MISO sampled just before the rise.
    task automatic xfer_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        wait_clk(HALF);
        mi = spi_miso;
        spi_sck = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic mi;
        for (int i = n - 1; i >= 0; i--) xfer_bit(v[i], mi);
    endtask

    task automatic cs_open();
        spi_cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_close();
        wait_clk(HALF);
        spi_cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic ld_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        wait_clk(1);
        ld_en   = 1'b0;
        mem_model[a] = d;
    endtask

    // Shift one word out of the DUT and compare with the scoreboard head.
    task automatic read_word(input string tag);
        logic [DATA_W-1:0] w;
        logic mi;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            xfer_bit(1'($urandom_range(0, 1)), mi);
            w[i] = mi;
        end
        if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        else check_eq(tag, 32'(w), 32'(exp_q.pop_front()));
    endtask

    // Opcode + address, plus dummy cycles for FAST READ; returns MISO ones seen.
    task automatic start_cmd(input logic [7:0] op, input logic [23:0] addr, output int ones);
        logic mi;
        ones = 0;
        cs_open();
        send_bits(32'(op), 8);
        send_bits(32'(addr), 24);
        if (op == 8'h0B) begin
            for (int i = 0; i < 8; i++) begin
                xfer_bit(1'($urandom_range(0, 1)), mi);
                ones += int'(mi);
            end
        end
    endtask

    task automatic do_read(input string tag, input logic [7:0] op, input logic [23:0] addr,
                           input int n);
        int ones;
        for (int i = 0; i < n; i++) exp_q.push_back(mem_model[(int'(addr[3:0]) + i) % 16]);
        start_cmd(op, addr, ones);
        if (op == 8'h0B) check_eq({tag, "_dummy_quiet"}, 32'(ones), 32'd0);
        for (int i = 0; i < n; i++) read_word($sformatf("%s_w%0d", tag, i));
        cs_close();
        check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'(n));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] init_words [16];
        logic [DATA_W-1:0] w;
        logic              mi;
        int                ones;

        init_words = '{16'h620A, 16'h6414, 16'h0650, 16'h8600, 16'h7800, 16'hF700,
                       16'hA002, 16'h6BFF, 16'h6C64, 16'h9FFF, 16'h0A0A, 16'h1B1B,
                       16'hC3C3, 16'h5AA5, 16'h0F0F, 16'hD00D};
        rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);
        check_eq("rst_miso", 32'(spi_miso), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cmd_err", 32'(cmd_err), 32'd0);
        check_eq("rst_word_cnt", 32'(word_cnt), 32'd0);

        for (int i = 0; i < 16; i++) ld_write(4'(i), init_words[i]);

        // READ at 2, two words, busy observed while selected
        exp_q.push_back(mem_model[2]);
        exp_q.push_back(mem_model[3]);
        start_cmd(8'h03, 24'h000002, ones);
        read_word("read2_w0");
        read_word("read2_w1");
        check_eq("read2_busy_hi", 32'(busy), 32'd1);
        cs_close();
        check_eq("read2_word_cnt", 32'(word_cnt), 32'd2);
        check_eq("read2_busy_lo", 32'(busy), 32'd0);

        do_read("fast0", 8'h0B, 24'h000000, 1);
        do_read("wrap", 8'h03, 24'h00000F, 3);

        // Unsupported opcode: MISO silent, error flag held until next command
        start_cmd(8'h9F, 24'h000000, ones);
        for (int i = 0; i < 16; i++) begin
            xfer_bit(1'($urandom_range(0, 1)), mi);
            ones += int'(mi);
        end
        check_eq("bad_op_quiet", 32'(ones), 32'd0);
        check_eq("bad_op_cmd_err", 32'(cmd_err), 32'd1);
        cs_close();
        check_eq("bad_op_err_held", 32'(cmd_err), 32'd1);
        cs_open();
        check_eq("cmd_err_cleared", 32'(cmd_err), 32'd0);
        spi_cs = 1'b1;
        wait_clk(8);
        do_read("after_err", 8'h03, 24'h000004, 1);

        // Partial word: no count, next read restarts at MSB
        start_cmd(8'h03, 24'h000005, ones);
        w = '0;
        for (int i = 4; i >= 0; i--) begin
            xfer_bit(1'b0, mi);
            w[i] = mi;
        end
        cs_close();
        check_eq("partial_bits", 32'(w[4:0]), 32'(mem_model[5][15:11]));
        check_eq("partial_busy", 32'(busy), 32'd0);
        check_eq("partial_word_cnt", 32'(word_cnt), 32'd0);
        do_read("restart", 8'h03, 24'h000005, 1);

        // Backdoor writes while word 2 streams: word 2 already loaded, word 3 not
        exp_q.push_back(mem_model[2]);
        start_cmd(8'h03, 24'h000002, ones);
        for (int i = DATA_W - 1; i >= 8; i--) begin
            xfer_bit(1'b0, mi);
            w[i] = mi;
        end
        ld_write(4'd2, 16'h1234);
        ld_write(4'd3, 16'hBEEF);
        exp_q.push_back(mem_model[3]);
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b0, mi);
            w[i] = mi;
        end
        check_eq("bd_word2", 32'(w), 32'(exp_q.pop_front()));
        read_word("bd_word3");
        cs_close();

        // Reset mid-DATA with a 1 on MISO, then CS left low must be ignored
        start_cmd(8'h03, 24'h000000, ones);
        xfer_bit(1'b0, mi);
        xfer_bit(1'b0, mi);
        wait_clk(4);
        check_eq("pre_rst_miso", 32'(spi_miso), 32'(mem_model[0][13]));
        rst = 1'b1;
        wait_clk(1);
        check_eq("mid_rst_miso", 32'(spi_miso), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            xfer_bit(1'($urandom_range(0, 1)), mi);
            ones += int'(mi);
        end
        check_eq("post_rst_quiet", 32'(ones), 32'd0);
        cs_close();
        do_read("recover", 8'h03, 24'h000001, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
